sram_port_arbiter: RTL and testbench

- Shares one port of the dual-port SRAM macro between two requesters, M0 (core data side) and M1 (DMA/debug side).
- Grants at most one access per cycle using round-robin with bounded burst lock.
- Drives the SRAM chip-select, address, write-enable, byte-enable and write-data pins.
- Returns read data to the granted requester one cycle after the access.

---
 rtl/sram_port_arbiter_if.sv | 47 ++++
 rtl/sram_port_arbiter.sv | 124 ++++++++++++
 tb/tb_sram_port_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_if.sv
// Bundles the two requester ports and the SRAM pin set of sram_port_arbiter.
// The slave modport is the arbiter's view; master is the requesters/SRAM side.
interface sram_port_arbiter_if #(
   parameter int AW = 12,
   parameter int DW = 32
);
   logic              M0_REQ;
   logic [AW-1:0]     M0_ADDR;
   logic              M0_WE;
   logic [DW/8-1:0]   M0_BE;
   logic [DW-1:0]     M0_WDATA;
   logic              M0_GNT;
   logic              M0_RVALID;

   logic              M1_REQ;
   logic [AW-1:0]     M1_ADDR;
   logic              M1_WE;
   logic [DW/8-1:0]   M1_BE;
   logic [DW-1:0]     M1_WDATA;
   logic              M1_GNT;
   logic              M1_RVALID;

   logic [DW-1:0]     RDATA;

   logic              SRAM_CSN;
   logic [AW-1:0]     SRAM_ADDR;
   logic              SRAM_WE;
   logic [DW/8-1:0]   SRAM_BE;
   logic [DW-1:0]     SRAM_DI;
   logic [DW-1:0]     SRAM_DO;

   modport slave (
      input  M0_REQ, M0_ADDR, M0_WE, M0_BE, M0_WDATA,
      input  M1_REQ, M1_ADDR, M1_WE, M1_BE, M1_WDATA,
      input  SRAM_DO,
      output M0_GNT, M0_RVALID, M1_GNT, M1_RVALID, RDATA,
      output SRAM_CSN, SRAM_ADDR, SRAM_WE, SRAM_BE, SRAM_DI
   );

   modport master (
      output M0_REQ, M0_ADDR, M0_WE, M0_BE, M0_WDATA,
      output M1_REQ, M1_ADDR, M1_WE, M1_BE, M1_WDATA,
      output SRAM_DO,
      input  M0_GNT, M0_RVALID, M1_GNT, M1_RVALID, RDATA,
      input  SRAM_CSN, SRAM_ADDR, SRAM_WE, SRAM_BE, SRAM_DI
   );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter for one SRAM port: round-robin with a bounded burst
// lock, combinational grant/pin muxing, one-cycle registered read valid.
// Optional macro SRAM_ARB_STATS_EN adds a saturating 16-bit CONFLICT_CNT
// output counting cycles where both requesters are asking.
module sram_port_arbiter #(
   parameter int AW        = 12,
   parameter int DW        = 32,
   parameter int MAX_BURST = 4
) (
   input  logic               CLK,
   input  logic               RESETn,
   sram_port_arbiter_if.slave bus
`ifdef SRAM_ARB_STATS_EN
   ,
   output logic [15:0]        CONFLICT_CNT
`endif
);

   localparam int BW = DW / 8;
   localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CW-1:0] BEAT_MAX = CW'(MAX_BURST - 1);

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_M0   = 2'd1;
   localparam logic [1:0] OWN_M1   = 2'd2;

   logic [1:0]    owner;
   logic          last_m1;     // 1 = M1 was granted most recently
   logic [CW-1:0] beat_cnt;
   logic          m0_rvalid;
   logic          m1_rvalid;
   logic          gnt0;
   logic          gnt1;
   logic          lock_hold;

   // Arbitration: burst lock first, then round-robin tie break, then single request.
   always_comb begin
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      lock_hold = (((owner == OWN_M0) && bus.M0_REQ) || ((owner == OWN_M1) && bus.M1_REQ))
                  && (beat_cnt < BEAT_MAX);
      if (lock_hold) begin
         gnt0 = (owner == OWN_M0);
         gnt1 = (owner == OWN_M1);
      end else if (bus.M0_REQ && bus.M1_REQ) begin
         gnt0 = last_m1;
         gnt1 = !last_m1;
      end else begin
         gnt0 = bus.M0_REQ;
         gnt1 = bus.M1_REQ;
      end
   end

   // SRAM pin mux; reads force full byte enables so DO is fully refreshed.
   always_comb begin
      bus.SRAM_CSN  = 1'b1;
      bus.SRAM_ADDR = '0;
      bus.SRAM_WE   = 1'b0;
      bus.SRAM_BE   = '0;
      bus.SRAM_DI   = '0;
      if (gnt0) begin
         bus.SRAM_CSN  = 1'b0;
         bus.SRAM_ADDR = bus.M0_ADDR;
         bus.SRAM_WE   = bus.M0_WE;
         bus.SRAM_BE   = bus.M0_WE ? bus.M0_BE : {BW{1'b1}};
         bus.SRAM_DI   = bus.M0_WDATA;
      end else if (gnt1) begin
         bus.SRAM_CSN  = 1'b0;
         bus.SRAM_ADDR = bus.M1_ADDR;
         bus.SRAM_WE   = bus.M1_WE;
         bus.SRAM_BE   = bus.M1_WE ? bus.M1_BE : {BW{1'b1}};
         bus.SRAM_DI   = bus.M1_WDATA;
      end
   end

   assign bus.M0_GNT    = gnt0;
   assign bus.M1_GNT    = gnt1;
   assign bus.M0_RVALID = m0_rvalid;
   assign bus.M1_RVALID = m1_rvalid;
   assign bus.RDATA     = bus.SRAM_DO;

   // Ownership, round-robin pointer and burst beat counter.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         owner    <= OWN_NONE;
         last_m1  <= 1'b1;
         beat_cnt <= '0;
      end else if (gnt0 || gnt1) begin
         last_m1 <= gnt1;
         if (owner == (gnt1 ? OWN_M1 : OWN_M0)) begin
            if (beat_cnt != BEAT_MAX) beat_cnt <= beat_cnt + CW'(1);
         end else begin
            owner    <= gnt1 ? OWN_M1 : OWN_M0;
            beat_cnt <= '0;
         end
      end else begin
         owner    <= OWN_NONE;
         beat_cnt <= '0;
      end
   end

   // Read valid follows a read grant by exactly one cycle; writes never return data.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
      end else begin
         m0_rvalid <= gnt0 && !bus.M0_WE;
         m1_rvalid <= gnt1 && !bus.M1_WE;
      end
   end

`ifdef SRAM_ARB_STATS_EN
   // Saturating count of cycles with both requesters contending.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         CONFLICT_CNT <= '0;
      end else if (bus.M0_REQ && bus.M1_REQ && (CONFLICT_CNT != 16'hFFFF)) begin
         CONFLICT_CNT <= CONFLICT_CNT + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural synchronous SRAM.
module tb_sram_port_arbiter;

   logic CLK;
   logic RESETn;
   int   n_chk;
   int   n_fail;

   logic [31:0] mem [0:4095];

   sram_port_arbiter_if #(.AW(12), .DW(32)) bus ();

`ifdef SRAM_ARB_STATS_EN
   logic [15:0] CONFLICT_CNT;
`endif

   sram_port_arbiter #(.AW(12), .DW(32), .MAX_BURST(4)) dut (
      .CLK    (CLK),
      .RESETn (RESETn),
      .bus    (bus)
`ifdef SRAM_ARB_STATS_EN
      ,
      .CONFLICT_CNT (CONFLICT_CNT)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Synchronous SRAM: byte-masked write, read data appears after the edge.
   always @(posedge CLK) begin
      if (!bus.SRAM_CSN) begin
         if (bus.SRAM_WE) begin
            for (int b = 0; b < 4; b++)
               if (bus.SRAM_BE[b]) mem[bus.SRAM_ADDR][8*b +: 8] <= bus.SRAM_DI[8*b +: 8];
         end else begin
            bus.SRAM_DO <= mem[bus.SRAM_ADDR];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.M0_REQ = 1'b0; bus.M0_ADDR = '0; bus.M0_WE = 1'b0; bus.M0_BE = '0; bus.M0_WDATA = '0;
      bus.M1_REQ = 1'b0; bus.M1_ADDR = '0; bus.M1_WE = 1'b0; bus.M1_BE = '0; bus.M1_WDATA = '0;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      logic exp0;
      n_chk  = 0;
      n_fail = 0;
      for (int i = 0; i < 4096; i++) mem[i] = 32'h0000_0000 ^ i;
      mem[12'h010] = 32'hDEADBEEF;
      mem[12'h020] = 32'hAAAAAAAA;
      idle_inputs();
      RESETn = 1'b0;

      // Reset state
      #12;
      chk("rst_m0_rvalid", bus.M0_RVALID, 0);
      chk("rst_m1_rvalid", bus.M1_RVALID, 0);
      chk("rst_csn",       bus.SRAM_CSN,  1);
      chk("rst_we",        bus.SRAM_WE,   0);
      chk("rst_addr",      bus.SRAM_ADDR, 0);
      chk("rst_be",        bus.SRAM_BE,   0);
      chk("rst_di",        bus.SRAM_DI,   0);
      chk("rst_gnt",       {bus.M0_GNT, bus.M1_GNT}, 0);
      RESETn = 1'b1;

      // Single read by M0
      @(negedge CLK);
      bus.M0_REQ = 1'b1; bus.M0_ADDR = 12'h010; bus.M0_WE = 1'b0; bus.M0_BE = 4'h1;
      #1;
      chk("rd_m0_gnt",  bus.M0_GNT,    1);
      chk("rd_m1_gnt",  bus.M1_GNT,    0);
      chk("rd_csn",     bus.SRAM_CSN,  0);
      chk("rd_addr",    bus.SRAM_ADDR, 12'h010);
      chk("rd_be_full", bus.SRAM_BE,   4'hF);
      chk("rd_we",      bus.SRAM_WE,   0);
      tick();
      bus.M0_REQ = 1'b0;
      chk("rd_m0_rvalid", bus.M0_RVALID, 1);
      chk("rd_rdata",     bus.RDATA,     32'hDEADBEEF);
      chk("rd_m1_rvalid", bus.M1_RVALID, 0);
      @(negedge CLK);
      chk("rd_idle_csn",    bus.SRAM_CSN,  1);
      chk("rd_hold_rdata",  bus.RDATA,     32'hDEADBEEF);
      tick();
      chk("rd_rvalid_drop", bus.M0_RVALID, 0);

      // M1 write with partial byte enables, then read back
      bus.M1_REQ = 1'b1; bus.M1_ADDR = 12'h020; bus.M1_WE = 1'b1;
      bus.M1_BE = 4'hC; bus.M1_WDATA = 32'h12345678;
      #1;
      chk("wr_m1_gnt", bus.M1_GNT,   1);
      chk("wr_we",     bus.SRAM_WE,  1);
      chk("wr_be",     bus.SRAM_BE,  4'hC);
      chk("wr_di",     bus.SRAM_DI,  32'h12345678);
      tick();
      chk("wr_no_rvalid", bus.M1_RVALID, 0);
      bus.M1_WE = 1'b0;
      #1;
      chk("wr_rd_gnt", bus.M1_GNT,  1);
      chk("wr_rd_be",  bus.SRAM_BE, 4'hF);
      tick();
      bus.M1_REQ = 1'b0;
      chk("wr_rd_rvalid",    bus.M1_RVALID, 1);
      chk("wr_rd_m0_rvalid", bus.M0_RVALID, 0);
      chk("wr_rd_rdata",     bus.RDATA,     32'h1234AAAA);

      // Contention from reset: M0 x4, M1 x4, M0 x2
      RESETn = 1'b0;
      tick();
      RESETn = 1'b1;
      bus.M0_REQ = 1'b1; bus.M0_ADDR = 12'h010; bus.M0_WE = 1'b0;
      bus.M1_REQ = 1'b1; bus.M1_ADDR = 12'h020; bus.M1_WE = 1'b0;
      for (int i = 0; i < 10; i++) begin
         exp0 = (i < 4) || (i >= 8);
         #1;
         chk($sformatf("cont_m0_gnt_%0d", i), bus.M0_GNT, exp0);
         chk($sformatf("cont_m1_gnt_%0d", i), bus.M1_GNT, !exp0);
         tick();
         chk($sformatf("cont_m0_rvalid_%0d", i), bus.M0_RVALID, exp0);
         chk($sformatf("cont_m1_rvalid_%0d", i), bus.M1_RVALID, !exp0);
         chk($sformatf("cont_rdata_%0d", i), bus.RDATA, exp0 ? 32'hDEADBEEF : 32'h1234AAAA);
      end
      idle_inputs();

      // Uncontested M1 for 8 cycles, then M0 joins once M1 has saturated its burst
      bus.M1_REQ = 1'b1; bus.M1_ADDR = 12'h030; bus.M1_WE = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk($sformatf("unc_m1_gnt_%0d", i), bus.M1_GNT, 1);
         chk($sformatf("unc_m0_gnt_%0d", i), bus.M0_GNT, 0);
         tick();
      end
      bus.M0_REQ = 1'b1; bus.M0_ADDR = 12'h010; bus.M0_WE = 1'b0;
      #1;
      chk("unc_join_m0_gnt", bus.M0_GNT, 1);
      chk("unc_join_m1_gnt", bus.M1_GNT, 0);
      tick();
      chk("unc_lock_m0_gnt", bus.M0_GNT, 1);
      chk("unc_lock_m1_gnt", bus.M1_GNT, 0);
      tick();
      idle_inputs();
      tick();

      // Reset in the cycle after a read grant
      bus.M0_REQ = 1'b1; bus.M0_ADDR = 12'h010; bus.M0_WE = 1'b0;
      #1;
      chk("mid_m0_gnt", bus.M0_GNT, 1);
      tick();
      bus.M0_REQ = 1'b0;
      chk("mid_pre_rvalid", bus.M0_RVALID, 1);
      RESETn = 1'b0;
      #1;
      chk("mid_rvalid_drop", bus.M0_RVALID, 0);
      chk("mid_csn",         bus.SRAM_CSN,  1);
      tick();
      RESETn = 1'b1;
      tick();
      chk("mid_no_late_rvalid", bus.M0_RVALID, 0);
      bus.M0_REQ = 1'b1; bus.M1_REQ = 1'b1;
      bus.M1_ADDR = 12'h020; bus.M1_WE = 1'b0;
      #1;
      chk("mid_tie_m0_gnt", bus.M0_GNT, 1);
      chk("mid_tie_m1_gnt", bus.M1_GNT, 0);
      tick();
      idle_inputs();

`ifdef SRAM_ARB_STATS_EN
      // Conflict counter: 5 dual-request cycles, then drive it into saturation
      RESETn = 1'b0;
      tick();
      RESETn = 1'b1;
      chk("stat_rst", CONFLICT_CNT, 0);
      bus.M0_REQ = 1'b1; bus.M1_REQ = 1'b1;
      repeat (5) tick();
      chk("stat_five", CONFLICT_CNT, 5);
      repeat (65535) tick();
      chk("stat_sat", CONFLICT_CNT, 16'hFFFF);
      idle_inputs();
      tick();
      chk("stat_hold", CONFLICT_CNT, 16'hFFFF);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
